uart_rx_oversampled: RTL and testbench

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

---
 rtl/uart_rx_oversampled.sv | 159 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per bit and a
// single-entry valid/ready holding register with frame-error and overrun pulses.
module uart_rx_oversampled #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic             rx_meta;
  logic             rxs;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       s;
  logic [2:0]       state;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             v7;
  logic             v8;

  logic tick;
  logic start_det;
  logic decide;
  logic bit_end;
  logic vote;
  logic byte_done;
  logic stop_bad;

  // Synchronizer resets to the idle level so reset release never looks like a start edge.
  // NOTE: every clocked block uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // NOTE: decode terms are continuous assigns, so there is no partially-assigned comb block to latch.
  assign start_det = (state == IDLE) && !rxs;
  assign tick      = (div_cnt == DIV_LAST);
  assign decide    = tick && (s == 4'd9);
  assign bit_end   = tick && (s == 4'd15);
  assign vote      = (v7 & v8) | (v7 & rxs) | (v8 & rxs);
  assign byte_done = (state == STOP) && decide && vote;
  assign stop_bad  = (state == STOP) && decide && !vote;

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (start_det || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      s <= 4'd0;
    end else if (start_det) begin
      s <= 4'd0;
    end else if (tick) begin
      s <= s + 4'd1;
    end
  end

  // The first two vote samples are held until the third arrives at s=9.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      v7 <= 1'b0;
      v8 <= 1'b0;
    end else if (tick) begin
      if (s == 4'd7) v7 <= rxs;
      if (s == 4'd8) v8 <= rxs;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) state <= START;
        end
        START: begin
          if (decide && vote) begin
            state <= IDLE;
          end else if (bit_end) begin
            state   <= DATA;
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (decide) shreg <= {vote, shreg[7:1]};
          if (bit_end) begin
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (decide) state <= vote ? IDLE : BREAK;
        end
        BREAK: begin
          // A held-low line must return high before another start is accepted.
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completing byte wins over a same-cycle handshake; it is only dropped when the
  // holding register is full and not being drained.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= stop_bad;
      overrun     <= 1'b0;
      if (byte_done) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled at DIV=10 (160 clocks/bit): table of frames plus
// hand-written overrun, break, glitch, same-cycle handshake and mid-frame reset sequences.
module tb_uart_rx_oversampled;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;

  uart_rx_oversampled #(
    .CLK_FREQ(1600000),
    .BAUD    (10000)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int fe_long = 0;
  int ov_long = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_hs;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid && rx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got byte %0h, expected none", rx_data);
        end else begin
          check("sb_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_error && fe_prev) fe_long++;
      if (overrun && ov_prev) ov_long++;
    end
    fe_prev = frame_error;
    ov_prev = overrun;
  end

  initial begin
    int hs0, fe0, ov0;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_hs: 1, exp_fe: 0};
    vecs[1] = '{data: 8'h55, stop: 1'b1, exp_hs: 1, exp_fe: 0};
    vecs[2] = '{data: 8'h00, stop: 1'b1, exp_hs: 1, exp_fe: 0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_hs: 1, exp_fe: 0};
    vecs[4] = '{data: 8'h81, stop: 1'b1, exp_hs: 1, exp_fe: 0};
    vecs[5] = '{data: 8'h3C, stop: 1'b0, exp_hs: 0, exp_fe: 1};

    reset    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (5) step();
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    repeat (BIT_CLKS) step();

    // Table-driven frames, consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hs0 = hs_cnt;
      fe0 = fe_cnt;
      if (vecs[i].exp_hs != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) step();
      check($sformatf("vec%0d_bytes", i), hs_cnt - hs0, vecs[i].exp_hs);
      check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
    end

    // Bad stop bit followed by a held-low line, then a clean byte.
    hs0 = hs_cnt;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (3 * BIT_CLKS) step();
    check("break_fe_pulses", fe_cnt - fe0, 1);
    check("break_no_byte", hs_cnt - hs0, 0);
    rx = 1'b1;
    repeat (BIT_CLKS) step();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) step();
    check("after_break_byte", hs_cnt - hs0, 1);
    check("after_break_fe", fe_cnt - fe0, 1);

    // 40-clock glitch must be rejected as a false start.
    hs0 = hs_cnt;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx = 1'b0;
    repeat (40) step();
    rx = 1'b1;
    repeat (3 * BIT_CLKS) step();
    check("glitch_no_byte", hs_cnt - hs0, 0);
    check("glitch_no_fe", fe_cnt - fe0, 0);
    check("glitch_no_ov", ov_cnt - ov0, 0);

    // Overrun: second byte dropped while the first is held.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS) step();
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
    check("ovr_data_held", {24'd0, rx_data}, 32'h01);
    rx_ready = 1'b1;
    step();
    check("ovr_valid_falls", {31'd0, rx_valid}, 32'd0);
    repeat (BIT_CLKS) step();

    // Back-to-back with ready held, then a completion landing on the handshake cycle.
    ov0 = ov_cnt;
    hs0 = hs_cnt;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS) step();
    check("b2b_bytes", hs_cnt - hs0, 2);
    rx_ready = 1'b0;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS) step();
    check("hold_ff_valid", {31'd0, rx_valid}, 32'd1);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    rx = 1'b1;
    // Stop decision edge is 1543 clocks after the start bit is driven.
    repeat (102) step();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("same_cycle_valid", {31'd0, rx_valid}, 32'd1);
    check("same_cycle_data", {24'd0, rx_data}, 32'h00);
    repeat (57) step();
    rx_ready = 1'b1;
    repeat (BIT_CLKS) step();
    check("same_cycle_bytes", hs_cnt - hs0, 4);
    check("same_cycle_no_ov", ov_cnt - ov0, 0);

    // Reset in the middle of data bit 4, then a clean byte.
    hs0 = hs_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (80) step();
    reset = 1'b0;
    repeat (3) step();
    check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_frame_error", {31'd0, frame_error}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    repeat (2 * BIT_CLKS) step();
    check("midrst_no_byte", hs_cnt - hs0, 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) step();
    check("midrst_c3_byte", hs_cnt - hs0, 1);

    check("sb_drained", exp_q.size(), 0);
    check("fe_single_cycle", fe_long, 0);
    check("ov_single_cycle", ov_long, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
